// File: rtl/lfsr_rand_gen.sv
// Parametrised LFSR (Fibonacci or Galois) with seed load, zero-lockup recovery
// and a bounded rejection-sampling draw engine behind a req/done handshake.
module lfsr_rand_gen #(
  parameter int unsigned      WIDTH     = 12,
  parameter logic [WIDTH-1:0] TAPS      = 12'hE08,
  parameter logic [WIDTH-1:0] SEED      = 12'hB76,
  parameter bit               GALOIS    = 1'b0,
  parameter int unsigned      MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             req,
  input  logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rnd_out,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam int unsigned   TW       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

  typedef enum logic {IDLE, DRAW} state_e;

  state_e           fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             advance;
  logic [WIDTH-1:0] cand, nxt;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    if (GALOIS)
      return {s[WIDTH-2:0], 1'b0} ^ ({WIDTH{s[WIDTH-1]}} & {TAPS[WIDTH-2:0], 1'b1});
    else
      return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // Smear the highest set bit downward: smallest 2^m-1 covering v.
  function automatic logic [WIDTH-1:0] fill_ones(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    m = v;
    for (int sh = 1; sh < int'(WIDTH); sh = sh * 2) m = m | (m >> sh);
    return m;
  endfunction

  assign cand    = lfsr_q & mask_q;
  assign nxt     = lfsr_next(lfsr_q);
  assign advance = step_en || (fsm_q == DRAW) || (fsm_q == IDLE && req);

  always_comb begin
    fsm_d   = fsm_q;
    lim_d   = lim_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (req) begin
          fsm_d   = DRAW;
          lim_d   = limit;
          mask_d  = fill_ones(limit);
          tries_d = '0;
        end
      end
      DRAW: begin
        if (cand <= lim_q) begin
          rnd_d  = cand;
          done_d = 1'b1;
          fsm_d  = IDLE;
        end else if (tries_q == LAST_TRY) begin
          // Dropping the top mask bit guarantees the result is within range.
          rnd_d  = cand & (mask_q >> 1);
          done_d = 1'b1;
          fsm_d  = IDLE;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    lfsr_d = lfsr_q;
    wrap_d = 1'b0;
    if (load) begin
      lfsr_d = (load_value == '0) ? SEED : load_value;
    end else if (lfsr_q == '0) begin
      lfsr_d = SEED;
    end else if (advance) begin
      lfsr_d = nxt;
      wrap_d = (nxt == SEED);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      lfsr_q  <= SEED;
      lim_q   <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      lim_q   <= lim_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign busy    = (fsm_q == DRAW);
  assign done    = done_q;
  assign rnd_out = rnd_q;
  assign value   = lfsr_q;
  assign wrap    = wrap_q;

endmodule

// File: doc/lfsr_rand_gen.md
# lfsr_rand_gen

Parametrised LFSR pseudo-random generator with a bounded-draw request/done handshake. Generalises the fixed 12-bit XOR-shift register to any width, any tap set, Fibonacci or Galois form, explicit seed load and zero-lockup recovery. A client can request a value uniformly distributed in [0, limit] by rejection sampling, for example a random reaction delay. Sits between the game controller and the delay/timer counters, clocked from the system clock.

## Interface
- WIDTH, 12: LFSR state width, 3..32.
- TAPS, 12'hE08: Fibonacci tap mask. Bit k=1 means state[k] feeds the XOR. The default is the polynomial x^12+x^11+x^10+x^4+1 (maximal, period 4095). Bit WIDTH-1 must be 1.
- SEED, 12'hB76: reset and lockup-recovery state. Must be nonzero.
- GALOIS, 0: 0 selects Fibonacci update, 1 selects Galois update.
- MAX_TRIES, 16: draw attempts before fallback, at least 1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- step_en  in  1  advance LFSR one step this cycle (free-run stirring).
- load  in  1  load load_value into the LFSR this cycle.
- load_value  in  WIDTH  seed to load; 0 is replaced by SEED.
- req  in  1  start a draw; sampled only in IDLE.
- limit  in  WIDTH  inclusive upper bound; captured with req.
- busy  out  1  draw in progress (state DRAW).
- done  out  1  one-cycle pulse; rnd_out valid.
- rnd_out  out  WIDTH  drawn value; held until the next done.
- value  out  WIDTH  current LFSR state.
- wrap  out  1  one-cycle pulse the cycle after an advance produces state == SEED.

## Operation
- Fibonacci next state: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}.
- Galois next state: next = {state[WIDTH-2:0], 1'b0} ^ ({WIDTH{state[WIDTH-1]}} & {TAPS[WIDTH-2:0], 1'b1}).
- Advance condition: step_en, or FSM in DRAW, or req accepted in IDLE. Multiple conditions in one cycle still give exactly one step.
- Priority, highest first: reset, then load, then zero-lockup, then advance.
  - load: state ← load_value, or SEED if load_value == 0.
  - zero-lockup: if state == 0, state ← SEED.
- FSM states IDLE and DRAW:
  - IDLE → DRAW on req. limit is captured into lim_r. mask_r is the smallest 2^m−1 ≥ limit (0 for limit 0). tries ← 0.
  - Each DRAW cycle: cand = state & mask_r.
    - If cand ≤ lim_r: rnd_out ← cand, done ← 1, go to IDLE.
    - Else, if tries == MAX_TRIES−1: rnd_out ← cand & (mask_r >> 1), which is always ≤ lim_r; done ← 1; go to IDLE.
    - Else: tries ← tries+1 and stay in DRAW. The LFSR advances.
- req while busy is ignored, with no queueing. limit changes during DRAW are ignored.
- load during DRAW takes effect; the next DRAW cycle evaluates the loaded state.

## Timing
- Reset values: state = SEED, value = SEED, FSM = IDLE, busy = 0, done = 0, rnd_out = 0, wrap = 0, tries = 0.
- value is registered and updates the cycle after the advance, load, or recovery.
- Draw latency: req is sampled at edge T. DRAW runs in cycles T+1 … T+n, where n is the number of attempts. done is high in cycle T+n+1.
  - Minimum latency is 2 cycles; maximum is MAX_TRIES+1.
  - busy is high exactly during the DRAW cycles.
- A new req is accepted in the same cycle done is high, since the FSM is then in IDLE.
- Reset mid-draw: abort with no done pulse. busy = 0 and the LFSR returns to SEED on the next edge.
- wrap and done are single-cycle pulses; never held.

## Test plan
- Reset, then one step_en, defaults, Fibonacci: value 0xB76 → 0x6EC → 0xDD9 on successive steps; busy, done and wrap stay 0.
- GALOIS=1, reset, one step_en: value 0xB76 → 0xAFD.
- Period: 4095 consecutive step_en from reset → value returns to 0xB76. wrap pulses exactly once, after step 4095. No intermediate value is 0 or repeats.
- Draw from reset with req and limit=100 at cycle T: DRAW at T+1 evaluates 0x6EC&0x7F = 108 and rejects. T+2 evaluates 0xDD9&0x7F = 0x59 and accepts. done in T+3 with rnd_out = 0x059; busy high for T+1..T+2.
- Boundaries:
  - limit = 0 → rnd_out = 0 at T+2.
  - load with load_value = 0 → value = 0xB76.
  - req asserted during busy → ignored, only one done.
  - load during DRAW → the next evaluation uses the loaded state.
- Fallback: MAX_TRIES=1, limit=100, seed 0xB76 → done at T+2, rnd_out = 0x6C & 0x3F = 0x2C. Randomised limits: rnd_out ≤ limit always.
